// File: rtl/ahb_pkg.sv
// ============================================================================
// Package  : ahb_pkg
// Summary  : Shared AHB bus encodings, arbiter state enum and burst-length
//            decode used by the round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_pkg;

    // Address-phase transfer type
    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_busy   = 2'b01;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_htrans_seq    = 2'b11;

    // Slave response
    localparam logic [1:0] c_hresp_okay  = 2'b00;
    localparam logic [1:0] c_hresp_error = 2'b01;
    localparam logic [1:0] c_hresp_retry = 2'b10;
    localparam logic [1:0] c_hresp_split = 2'b11;

    // Burst type
    localparam logic [2:0] c_hburst_single = 3'b000;
    localparam logic [2:0] c_hburst_incr   = 3'b001;
    localparam logic [2:0] c_hburst_wrap4  = 3'b010;
    localparam logic [2:0] c_hburst_incr4  = 3'b011;
    localparam logic [2:0] c_hburst_wrap8  = 3'b100;
    localparam logic [2:0] c_hburst_incr8  = 3'b101;
    localparam logic [2:0] c_hburst_wrap16 = 3'b110;
    localparam logic [2:0] c_hburst_incr16 = 3'b111;

    // Arbiter ownership state
    typedef enum logic [1:0] {
        ST_PARK   = 2'd0,
        ST_OWN    = 2'd1,
        ST_BURST  = 2'd2,
        ST_LOCKED = 2'd3
    } arb_state_e;

    // Number of beats in a burst; 0 marks an unbounded INCR burst
    function automatic logic [4:0] burst_len(input logic [2:0] hb);
        logic [4:0] len;
        case (hb)
            c_hburst_single:                   len = 5'd1;
            c_hburst_incr:                     len = 5'd0;
            c_hburst_wrap4,  c_hburst_incr4:   len = 5'd4;
            c_hburst_wrap8,  c_hburst_incr8:   len = 5'd8;
            c_hburst_wrap16, c_hburst_incr16:  len = 5'd16;
            default:                           len = 5'd1;
        endcase
        return len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_rr_pick.sv
// ============================================================================
// Module   : ahb_rr_pick
// Summary  : Combinational rotating priority encoder. Searches the request
//            vector starting one position after the pointer and wraps; the
//            pointer position itself is examined last.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MW-1:0]          ptr,
    output logic [MW-1:0]          winner,
    output logic                   valid
);

    logic [MW-1:0] w_idx;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_idx  = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_idx = MW'((int'(ptr) + k) % NUM_MASTERS);
            if (req[w_idx]) begin
                winner = w_idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ahb_rr_arbiter.sv
// ============================================================================
// Module   : ahb_rr_arbiter
// Summary  : Round-robin AHB bus arbiter. Holds ownership across fixed-length
//            bursts and locked sequences, parks on DEFAULT_MASTER when idle,
//            and hands the address phase over on the next hready edge.
// Optional : define AHB_ARB_SPLIT_EN to add the split mask driven by hsplit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = 2
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic [1:0]             hresp,
    input  logic [NUM_MASTERS-1:0] hsplit,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock
);

    localparam logic [MW-1:0]          c_def_idx   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] c_def_grant = NUM_MASTERS'(1) << DEFAULT_MASTER;

    // Registered state
    arb_state_e             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [MW-1:0]          r_owner;
    logic [MW-1:0]          r_ptr;
    logic                   r_glock;
    logic [4:0]             r_cnt;
    logic                   r_incr;
    logic [MW-1:0]          r_hmaster;
    logic                   r_hmastlock;

    // Combinational
    arb_state_e             w_state_nxt;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [MW-1:0]          w_owner_nxt;
    logic [MW-1:0]          w_ptr_nxt;
    logic                   w_glock_nxt;
    logic                   w_do_arb;
    logic [4:0]             w_blen;
    logic                   w_others;
    logic                   w_incr_xfer;
    logic                   w_retry;
    logic                   w_arb;
    logic                   w_owner_lock;
    logic [NUM_MASTERS-1:0] w_mask;
    logic [NUM_MASTERS-1:0] w_elig;
    logic [MW-1:0]          w_win;
    logic                   w_win_valid;

    assign w_blen       = burst_len(hburst);
    assign w_others     = |(hbusreq & ~r_grant);
    assign w_owner_lock = hlock[r_owner];
    assign w_incr_xfer  = ((htrans == c_htrans_nonseq) && (hburst == c_hburst_incr)) ||
                          ((htrans == c_htrans_seq) && r_incr);
    // RETRY and SPLIT both release the bus on their second (hready) cycle
    assign w_retry      = (hresp != c_hresp_okay) && (hresp != c_hresp_error);

    // Arbitration point; BUSY matches none of the terms
    assign w_arb = hready && ((htrans == c_htrans_idle) ||
                              ((htrans == c_htrans_nonseq) && (hburst == c_hburst_single)) ||
                              ((htrans == c_htrans_seq) && !r_incr && (r_cnt <= 5'd1)) ||
                              (w_incr_xfer && w_others) ||
                              w_retry);

`ifdef AHB_ARB_SPLIT_EN
    logic [NUM_MASTERS-1:0] r_mask;
    logic [NUM_MASTERS-1:0] w_mask_nxt;

    // Split mask: set for the split master, cleared by hsplit; default never masked
    always_comb begin
        w_mask_nxt = r_mask;
        if (!hready && (hresp == c_hresp_split)) begin
            w_mask_nxt[r_hmaster] = 1'b1;
        end
        w_mask_nxt            = w_mask_nxt & ~hsplit;
        w_mask_nxt[c_def_idx] = 1'b0;
    end

    // Split mask register
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_mask <= '0;
        end else begin
            r_mask <= w_mask_nxt;
        end
    end

    assign w_mask = r_mask;
`else
    logic w_unused_split;
    assign w_unused_split = ^hsplit;
    assign w_mask         = '0;
`endif

    assign w_elig = hbusreq & ~w_mask;

    ahb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_pick (
        .req    (w_elig),
        .ptr    (r_ptr),
        .winner (w_win),
        .valid  (w_win_valid)
    );

    // Next-state: lock holds the bus, otherwise re-arbitrate at arbitration points
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_glock_nxt = r_glock;
        w_do_arb    = 1'b0;
        w_grant_nxt = '0;

        if (r_state == ST_LOCKED) begin
            w_do_arb = w_arb && !w_owner_lock;
        end else if (w_owner_lock) begin
            w_state_nxt = ST_LOCKED;
            w_glock_nxt = 1'b1;
        end else if (w_arb) begin
            w_do_arb = 1'b1;
        end else if (hready && (htrans == c_htrans_nonseq) && (w_blen > 5'd1)) begin
            w_state_nxt = ST_BURST;
        end

        if (w_do_arb) begin
            if (w_win_valid) begin
                w_owner_nxt = w_win;
                w_ptr_nxt   = w_win;
                w_glock_nxt = hlock[w_win];
                w_state_nxt = ST_OWN;
            end else begin
                w_owner_nxt = c_def_idx;
                w_glock_nxt = 1'b0;
                w_state_nxt = ST_PARK;
            end
        end

        w_grant_nxt[w_owner_nxt] = 1'b1;
    end

    // Grant, pointer and state registers
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state <= ST_PARK;
            r_grant <= c_def_grant;
            r_owner <= c_def_idx;
            r_ptr   <= c_def_idx;
            r_glock <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_glock <= w_glock_nxt;
        end
    end

    // Beat counter and INCR flag track the accepted transfer stream
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_cnt  <= '0;
            r_incr <= 1'b0;
        end else if (hready) begin
            case (htrans)
                c_htrans_nonseq: begin
                    if (hburst == c_hburst_incr) begin
                        r_incr <= 1'b1;
                    end else begin
                        r_incr <= 1'b0;
                        r_cnt  <= w_blen - 5'd1;
                    end
                end
                c_htrans_seq: begin
                    if (r_cnt != 5'd0) begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                c_htrans_busy: ;
                default: ;
            endcase
        end
    end

    // Address-phase owner follows the grant on each accepted cycle
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_hmaster   <= c_def_idx;
            r_hmastlock <= 1'b0;
        end else if (hready) begin
            r_hmaster   <= r_owner;
            r_hmastlock <= r_glock;
        end
    end

    assign hgrant    = r_grant;
    assign hmaster   = r_hmaster;
    assign hmastlock = r_hmastlock;

endmodule

`default_nettype wire

// File: tb/tb_ahb_rr_arbiter.sv
// ============================================================================
// Module   : tb_ahb_rr_arbiter
// Summary  : Self-checking bench for ahb_rr_arbiter: vector table, directed
//            burst/lock/reset/split sequences and a randomized run against a
//            behavioural arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_rr_arbiter;

    localparam int N   = 4;
    localparam int DEF = 0;

    logic       hclk;
    logic       hreset;
    logic [3:0] hbusreq, hlock, hsplit;
    logic [1:0] htrans, hresp;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int n_chk;
    int n_err;

    ahb_rr_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (DEF),
        .MW             (2)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hresp     (hresp),
        .hsplit    (hsplit),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // ---------------- behavioural model ----------------
    int       m_owner, m_ptr, m_left, m_master;
    bit       m_incr, m_locked, m_glock, m_mlock;
    bit [3:0] m_mask;

    function automatic int blen(input logic [2:0] hb);
        if (hb == 3'd0) return 1;
        if (hb == 3'd1) return 0;
        return 4 << ((int'(hb) - 2) / 2);
    endfunction

    task automatic model_reset();
        m_owner = DEF; m_ptr = DEF; m_left = 0; m_master = DEF;
        m_incr = 0; m_locked = 0; m_glock = 0; m_mlock = 0; m_mask = '0;
    endtask

    task automatic model_arbitrate();
        int w;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (w < 0 && hbusreq[i] && !m_mask[i]) w = i;
        end
        m_locked = 0;
        if (w >= 0) begin
            m_owner = w; m_ptr = w; m_glock = hlock[w];
        end else begin
            m_owner = DEF; m_glock = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        int  old_master;
        bit  arb, others;
        if (hreset) begin
            model_reset();
            return;
        end
        old_master = m_master;
        others     = (hbusreq & ~(4'b0001 << m_owner)) != 4'b0000;
        arb        = 0;
        if (hready) begin
            case (htrans)
                2'b00: arb = 1;
                2'b10: begin
                    if (blen(hburst) == 0) begin
                        m_incr = 1;
                        if (others) arb = 1;
                    end else begin
                        m_incr = 0;
                        m_left = blen(hburst) - 1;
                        if (m_left == 0) arb = 1;
                    end
                end
                2'b11: begin
                    if (m_incr) begin
                        if (others) arb = 1;
                    end else begin
                        if (m_left > 0) m_left--;
                        if (m_left == 0) arb = 1;
                    end
                end
                default: ;
            endcase
            if (hresp[1]) arb = 1;
            m_master = m_owner;
            m_mlock  = m_glock;
        end
        if (m_locked) begin
            if (arb && !hlock[m_owner]) model_arbitrate();
        end else if (hlock[m_owner]) begin
            m_locked = 1;
            m_glock  = 1;
        end else if (arb) begin
            model_arbitrate();
        end
`ifdef AHB_ARB_SPLIT_EN
        if (!hready && hresp == 2'b11) m_mask[old_master] = 1;
        m_mask      = m_mask & ~hsplit;
        m_mask[DEF] = 0;
`else
        old_master = old_master;
`endif
    endtask

    // ---------------- stimulus / checking helpers ----------------
    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] lk,
                         input logic [1:0] tr, input logic [2:0] hb, input logic rdy,
                         input logic [1:0] rsp, input logic [3:0] spl);
        @(negedge hclk);
        hreset = rst; hbusreq = req; hlock = lk; htrans = tr;
        hburst = hb; hready = rdy; hresp = rsp; hsplit = spl;
        model_step();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic [1:0] tr;
        logic [2:0] hb;
        logic       rdy;
        logic [1:0] rsp;
        logic [3:0] g;
        logic [1:0] m;
    } vec_t;

    vec_t tbl[13];

    initial begin
        n_chk = 0; n_err = 0;
        hreset = 1; hbusreq = '0; hlock = '0; htrans = '0; hburst = '0;
        hready = 1; hresp = '0; hsplit = '0;
        model_reset();

        //            req      tr     hb      rdy   rsp    grant    hmaster
        tbl[0]  = '{4'b1111, 2'b10, 3'b000, 1'b1, 2'b00, 4'b0010, 2'd0};
        tbl[1]  = '{4'b1111, 2'b10, 3'b000, 1'b1, 2'b00, 4'b0100, 2'd1};
        tbl[2]  = '{4'b1111, 2'b10, 3'b000, 1'b1, 2'b00, 4'b1000, 2'd2};
        tbl[3]  = '{4'b1111, 2'b10, 3'b000, 1'b1, 2'b00, 4'b0001, 2'd3};
        tbl[4]  = '{4'b1111, 2'b10, 3'b000, 1'b1, 2'b00, 4'b0010, 2'd0};
        tbl[5]  = '{4'b1111, 2'b10, 3'b000, 1'b0, 2'b00, 4'b0010, 2'd0};
        tbl[6]  = '{4'b0000, 2'b00, 3'b000, 1'b1, 2'b00, 4'b0001, 2'd1};
        tbl[7]  = '{4'b0000, 2'b00, 3'b000, 1'b0, 2'b00, 4'b0001, 2'd1};
        tbl[8]  = '{4'b0000, 2'b00, 3'b000, 1'b1, 2'b00, 4'b0001, 2'd0};
        tbl[9]  = '{4'b0100, 2'b01, 3'b000, 1'b1, 2'b00, 4'b0001, 2'd0};
        tbl[10] = '{4'b0100, 2'b10, 3'b010, 1'b1, 2'b01, 4'b0001, 2'd0};
        tbl[11] = '{4'b0100, 2'b11, 3'b010, 1'b1, 2'b10, 4'b0100, 2'd0};
        tbl[12] = '{4'b0100, 2'b00, 3'b000, 1'b1, 2'b00, 4'b0100, 2'd2};

        // Reset state
        drive(1, 4'b0, 4'b0, 2'b00, 3'b0, 1, 2'b00, 4'b0);
        drive(1, 4'b0, 4'b0, 2'b00, 3'b0, 1, 2'b00, 4'b0);
        chk("reset_grant", hgrant, 4'b0001);
        chk("reset_hmaster", hmaster, 0);
        chk("reset_hmastlock", hmastlock, 0);

        // Round-robin, wait states, park, BUSY, ERROR and RETRY vectors
        for (int i = 0; i < 13; i++) begin
            drive(0, tbl[i].req, 4'b0, tbl[i].tr, tbl[i].hb, tbl[i].rdy, tbl[i].rsp, 4'b0);
            chk($sformatf("vec%0d_grant", i), hgrant, tbl[i].g);
            chk($sformatf("vec%0d_hmaster", i), hmaster, tbl[i].m);
            chk($sformatf("vec%0d_hmastlock", i), hmastlock, 0);
        end

        // Burst hold: master 2 runs INCR8 with master 1 waiting
        drive(1, 4'b0, 4'b0, 2'b00, 3'b0, 1, 2'b00, 4'b0);
        drive(0, 4'b0100, 4'b0, 2'b00, 3'b000, 1, 2'b00, 4'b0);
        drive(0, 4'b0100, 4'b0, 2'b00, 3'b000, 1, 2'b00, 4'b0);
        chk("burst_setup_hmaster", hmaster, 2);
        drive(0, 4'b0110, 4'b0, 2'b10, 3'b101, 1, 2'b00, 4'b0);
        chk("burst_beat1_grant", hgrant, 4'b0100);
        for (int b = 2; b <= 8; b++) begin
            if (b == 4) begin
                drive(0, 4'b0110, 4'b0, 2'b11, 3'b101, 0, 2'b00, 4'b0);
                chk("burst_wait_grant", hgrant, 4'b0100);
            end
            if (b == 6) begin
                drive(0, 4'b0110, 4'b0, 2'b01, 3'b101, 1, 2'b00, 4'b0);
                chk("burst_busy_grant", hgrant, 4'b0100);
            end
            drive(0, 4'b0110, 4'b0, 2'b11, 3'b101, 1, 2'b00, 4'b0);
            chk($sformatf("burst_beat%0d_grant", b), hgrant, (b == 8) ? 4'b0010 : 4'b0100);
        end
        drive(0, 4'b0010, 4'b0, 2'b00, 3'b000, 1, 2'b00, 4'b0);
        chk("burst_handover_hmaster", hmaster, 1);

        // Reset in the middle of an INCR16 burst, then counter must be clear
        drive(0, 4'b0011, 4'b0, 2'b10, 3'b111, 1, 2'b00, 4'b0);
        drive(0, 4'b0011, 4'b0, 2'b11, 3'b111, 1, 2'b00, 4'b0);
        chk("midburst_grant", hgrant, 4'b0010);
        drive(1, 4'b0011, 4'b0, 2'b11, 3'b111, 1, 2'b00, 4'b0);
        chk("midburst_reset_grant", hgrant, 4'b0001);
        chk("midburst_reset_hmaster", hmaster, 0);
        chk("midburst_reset_hmastlock", hmastlock, 0);
        drive(0, 4'b0010, 4'b0, 2'b11, 3'b111, 1, 2'b00, 4'b0);
        chk("post_reset_cnt_grant", hgrant, 4'b0010);

        // Locked sequence: master 3 holds the bus while master 0 waits
        drive(1, 4'b0, 4'b0, 2'b00, 3'b0, 1, 2'b00, 4'b0);
        drive(0, 4'b1000, 4'b1000, 2'b00, 3'b000, 1, 2'b00, 4'b0);
        chk("lock_grant", hgrant, 4'b1000);
        drive(0, 4'b1001, 4'b1000, 2'b10, 3'b000, 1, 2'b00, 4'b0);
        chk("lock_single1_grant", hgrant, 4'b1000);
        chk("lock_single1_hmaster", hmaster, 3);
        chk("lock_single1_hmastlock", hmastlock, 1);
        drive(0, 4'b1001, 4'b1000, 2'b10, 3'b000, 1, 2'b00, 4'b0);
        chk("lock_single2_grant", hgrant, 4'b1000);
        chk("lock_single2_hmastlock", hmastlock, 1);
        drive(0, 4'b1001, 4'b0000, 2'b00, 3'b000, 1, 2'b00, 4'b0);
        chk("unlock_grant", hgrant, 4'b0001);
        drive(0, 4'b0001, 4'b0000, 2'b00, 3'b000, 1, 2'b00, 4'b0);
        chk("unlock_hmaster", hmaster, 0);
        chk("unlock_hmastlock", hmastlock, 0);

`ifdef AHB_ARB_SPLIT_EN
        // Split: master 1 masked until hsplit releases it
        drive(1, 4'b0, 4'b0, 2'b00, 3'b0, 1, 2'b00, 4'b0);
        drive(0, 4'b0010, 4'b0, 2'b00, 3'b000, 1, 2'b00, 4'b0);
        drive(0, 4'b0010, 4'b0, 2'b00, 3'b000, 1, 2'b00, 4'b0);
        chk("split_setup_hmaster", hmaster, 1);
        drive(0, 4'b0010, 4'b0, 2'b10, 3'b000, 0, 2'b11, 4'b0);
        drive(0, 4'b0010, 4'b0, 2'b00, 3'b000, 1, 2'b11, 4'b0);
        chk("split_park_grant", hgrant, 4'b0001);
        drive(0, 4'b0010, 4'b0, 2'b00, 3'b000, 1, 2'b00, 4'b0);
        chk("split_masked_grant", hgrant, 4'b0001);
        drive(0, 4'b0010, 4'b0, 2'b00, 3'b000, 1, 2'b00, 4'b0010);
        drive(0, 4'b0010, 4'b0, 2'b00, 3'b000, 1, 2'b00, 4'b0);
        chk("split_release_grant", hgrant, 4'b0010);
`endif

        // Randomized run against the behavioural model
        drive(1, 4'b0, 4'b0, 2'b00, 3'b0, 1, 2'b00, 4'b0);
        for (int c = 0; c < 400; c++) begin
            logic [3:0] r_req, r_lk, r_spl;
            logic [1:0] r_rsp;
            r_req = 4'($urandom);
            r_lk  = 4'($urandom & $urandom & $urandom);
            r_spl = 4'($urandom & $urandom);
            r_rsp = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            drive(0, r_req, r_lk, 2'($urandom), 3'($urandom),
                  $urandom_range(0, 3) != 0, r_rsp, r_spl);
            chk($sformatf("rand%0d_grant", c), hgrant, 4'b0001 << m_owner);
            chk($sformatf("rand%0d_hmaster", c), hmaster, m_master);
            chk($sformatf("rand%0d_hmastlock", c), hmastlock, m_mlock);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
